// File: rtl/sap1_pkg.sv
// Shared constants and arbiter state encoding for the SAP-1 memory arbiter.
package sap1_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RV   = 2'd2,
        WR   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sap1_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a one-cycle rising-edge pulse
// derived from the synchronised level.
module sap1_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sap1_mem_arbiter.sv
// Arbitrates the single-port program/data memory between CPU reads and a pin-driven
// program loader; CPU reads win, but a pending loader byte is forced through after STARVE_MAX losses.
module sap1_mem_arbiter #(
    parameter int unsigned ADDR_W     = sap1_pkg::ADDR_W,
    parameter int unsigned DATA_W     = sap1_pkg::DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              ld_mode,
    input  logic              ld_strobe,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic              ld_busy,
    output logic              ld_overrun,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import sap1_pkg::*;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic mode_sync, mode_rise;
    logic strobe_rise, unused_strobe_lvl;

    sap1_sync_edge u_sync_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ld_mode),
        .sync_o (mode_sync),
        .rise_o (mode_rise)
    );

    sap1_sync_edge u_sync_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ld_strobe),
        .sync_o (unused_strobe_lvl),
        .rise_o (strobe_rise)
    );

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              cpu_req_eff;
    logic              wr_done;

    // Requests are masked in load mode so the CPU stalls and the loader sees an idle bus.
    assign cpu_req_eff = cpu_req & ~mode_sync;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        cpu_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = rdata_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (busy_q && (!cpu_req_eff || starve_q == StarveMax)) begin
                    state_d  = WR;
                    starve_d = '0;
                end else if (cpu_req_eff) begin
                    cpu_gnt = 1'b1;
                    raddr_d = cpu_addr;
                    state_d = RD;
                    if (busy_q) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            RD: begin
                mem_en   = 1'b1;
                mem_addr = raddr_q;
                state_d  = RV;
            end
            RV: begin
                // Memory data is presented straight through so it is valid with the pulse.
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
                rdata_d    = mem_rdata;
                state_d    = IDLE;
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = hold_addr_q;
                mem_wdata = hold_data_q;
                wr_done   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (wr_done) begin
            ptr_d  = ptr_q + 1'b1;
            busy_d = 1'b0;
        end
        if (mode_rise) begin
            ptr_d     = '0;
            overrun_d = 1'b0;
        end
        // A byte arriving during the freeing write takes the slot and the advanced pointer.
        if (strobe_rise) begin
            if (!busy_q || wr_done) begin
                busy_d      = 1'b1;
                hold_addr_d = ptr_d;
                hold_data_d = ld_data;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            raddr_q     <= '0;
            rdata_q     <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            raddr_q     <= raddr_d;
            rdata_q     <= rdata_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign cpu_hold   = mode_sync;
    assign ld_ptr     = ptr_q;
    assign ld_busy    = busy_q;
    assign ld_overrun = overrun_q;

endmodule

// File: tb/tb_sap1_mem_arbiter.sv
// Directed self-checking bench for sap1_mem_arbiter with a behavioural 16x8 memory.
module tb_sap1_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_gnt, cpu_rvalid, cpu_hold;
    logic [3:0] cpu_addr, ld_ptr, mem_addr;
    logic [7:0] cpu_rdata, ld_data, mem_wdata, mem_rdata;
    logic       ld_mode, ld_strobe, ld_busy, ld_overrun, mem_en, mem_we;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sap1_mem_arbiter #(
        .ADDR_W     (4),
        .DATA_W     (8),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_hold   (cpu_hold),
        .ld_mode    (ld_mode),
        .ld_strobe  (ld_strobe),
        .ld_data    (ld_data),
        .ld_ptr     (ld_ptr),
        .ld_busy    (ld_busy),
        .ld_overrun (ld_overrun),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural single-port memory: registered read one cycle after mem_en.
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    // Event monitor sampled on the falling edge.
    logic [3:0] wr_addr [64];
    logic [7:0] wr_data [64];
    int         wr_n = 0, gnt_n = 0, gnt_busy_n = 0, rv_n = 0, inv_n = 0, hold_bad = 0;
    logic [7:0] rv_data = 8'h00;
    bit         in_load = 1'b0;

    always @(negedge clk) begin
        if (mem_we && wr_n < 64) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_n++;
        end
        if (cpu_gnt) begin
            gnt_n++;
            if (ld_busy) gnt_busy_n++;
        end
        if (cpu_rvalid) begin
            rv_n++;
            rv_data = cpu_rdata;
        end
        if (mem_en && mem_we) inv_n++;
        if (cpu_gnt && cpu_hold) inv_n++;
        if (in_load && !cpu_hold) hold_bad++;
    end

    function automatic logic [30:0] outs_vec();
        return {cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold, ld_ptr, ld_busy, ld_overrun,
                mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output int lat,
                            output bit ok);
        ok = 1'b0;
        lat = -1;
        d = 8'h00;
        cpu_addr = a;
        cpu_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        cpu_req = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (cpu_rvalid) begin
                    ok = 1'b1;
                    lat = i;
                    d = cpu_rdata;
                    break;
                end
            end
        end
    endtask

    task automatic strobe_byte(input logic [7:0] d);
        ld_data = d;
        ld_strobe = 1'b1;
        tick();
        tick();
        ld_strobe = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int  rv0;
        bit  got;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (outs_vec() !== 31'h0) begin
            fails++;
            $display("FAIL reset_initial: outputs=%h required=0", outs_vec());
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        tests++;
        if (outs_vec() !== 31'h0) begin
            fails++;
            $display("FAIL reset_release: outputs=%h required=0", outs_vec());
        end
        cpu_addr = 4'd3;
        cpu_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                got = 1'b1;
                break;
            end
        end
        tick();
        cpu_req = 1'b0;
        tests++;
        if (!got || mem_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_read_started: gnt=%0b mem_en=%b required 1/1", got, mem_en);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (outs_vec() !== 31'h0) begin
            fails++;
            $display("FAIL reset_midread: outputs=%h required=0", outs_vec());
        end
        tick();
        rst_n = 1'b1;
        rv0 = rv_n;
        repeat (5) tick();
        tests++;
        if (rv_n != rv0 || ld_ptr !== 4'd0) begin
            fails++;
            $display("FAIL reset_no_rvalid: rvalids=%0d ptr=%0d required 0/0", rv_n - rv0, ld_ptr);
        end
    endtask

    task automatic test_load_program();
        int         w0, g0, lat;
        bit         ok;
        logic [7:0] d;
        ld_mode = 1'b1;
        repeat (4) tick();
        tests++;
        if (cpu_hold !== 1'b1 || ld_ptr !== 4'd0) begin
            fails++;
            $display("FAIL load_enter: hold=%b ptr=%0d required 1/0", cpu_hold, ld_ptr);
        end
        in_load = 1'b1;
        g0 = gnt_n;
        cpu_addr = 4'd0;
        cpu_req = 1'b1;
        repeat (6) tick();
        cpu_req = 1'b0;
        tests++;
        if (gnt_n != g0) begin
            fails++;
            $display("FAIL load_cpu_stall: grants=%0d required 0", gnt_n - g0);
        end
        w0 = wr_n;
        for (int i = 0; i < 16; i++) strobe_byte(8'(8'h10 + i));
        tests++;
        if (wr_n - w0 != 16) begin
            fails++;
            $display("FAIL load_write_count: writes=%0d required 16", wr_n - w0);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (w0 + i >= wr_n || wr_addr[w0 + i] !== 4'(i) || wr_data[w0 + i] !== 8'(8'h10 + i))
            begin
                fails++;
                $display("FAIL load_write_%0d: addr=%0d data=%h required %0d/%h", i,
                         wr_addr[(w0 + i) % 64], wr_data[(w0 + i) % 64], i, 8'(8'h10 + i));
            end
        end
        tests++;
        if (ld_ptr !== 4'd0 || ld_busy !== 1'b0 || ld_overrun !== 1'b0 || hold_bad != 0) begin
            fails++;
            $display("FAIL load_end_state: ptr=%0d busy=%b ovr=%b hold_drops=%0d required 0/0/0/0",
                     ld_ptr, ld_busy, ld_overrun, hold_bad);
        end
        in_load = 1'b0;
        ld_mode = 1'b0;
        repeat (4) tick();
        tests++;
        if (cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL load_exit: hold=%b required 0", cpu_hold);
        end
        cpu_read(4'd5, d, lat, ok);
        tests++;
        if (!ok || d !== 8'h15 || lat != 2) begin
            fails++;
            $display("FAIL load_readback: ok=%0b data=%h latency=%0d required 1/15/2", ok, d, lat);
        end
    endtask

    task automatic test_overrun();
        int w0;
        cpu_addr = 4'd1;
        cpu_req = 1'b1;
        repeat (2) tick();
        w0 = wr_n;
        ld_data = 8'hA5;
        ld_strobe = 1'b1;
        tick();
        ld_strobe = 1'b0;
        tick();
        ld_strobe = 1'b1;
        tick();
        ld_strobe = 1'b0;
        ld_data = 8'h5A;
        repeat (30) tick();
        cpu_req = 1'b0;
        repeat (4) tick();
        tests++;
        if (ld_overrun !== 1'b1 || ld_ptr !== 4'd1 || ld_busy !== 1'b0) begin
            fails++;
            $display("FAIL overrun_state: ovr=%b ptr=%0d busy=%b required 1/1/0",
                     ld_overrun, ld_ptr, ld_busy);
        end
        tests++;
        if (wr_n - w0 != 1 || wr_addr[w0 % 64] !== 4'd0 || wr_data[w0 % 64] !== 8'hA5) begin
            fails++;
            $display("FAIL overrun_write: writes=%0d addr=%0d data=%h required 1/0/a5",
                     wr_n - w0, wr_addr[w0 % 64], wr_data[w0 % 64]);
        end
    endtask

    task automatic test_starvation();
        int         gb0, gb;
        bit         seen;
        logic [3:0] wa;
        logic [7:0] wd;
        cpu_addr = 4'd2;
        cpu_req = 1'b1;
        tick();
        gb0 = gnt_busy_n;
        ld_data = 8'h77;
        ld_strobe = 1'b1;
        tick();
        tick();
        ld_strobe = 1'b0;
        seen = 1'b0;
        wa = 4'd0;
        wd = 8'h00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1'b1;
                wa = mem_addr;
                wd = mem_wdata;
                break;
            end
        end
        gb = gnt_busy_n - gb0;
        tick();
        cpu_req = 1'b0;
        repeat (6) tick();
        tests++;
        if (!seen || gb != 4) begin
            fails++;
            $display("FAIL starve_grants: write_seen=%0b grants_while_pending=%0d required 1/4",
                     seen, gb);
        end
        tests++;
        if (wa !== 4'd1 || wd !== 8'h77 || ld_ptr !== 4'd2) begin
            fails++;
            $display("FAIL starve_write: addr=%0d data=%h ptr=%0d required 1/77/2", wa, wd, ld_ptr);
        end
        tests++;
        if (rv_data !== 8'h12) begin
            fails++;
            $display("FAIL starve_cpu_data: rdata=%h required 12", rv_data);
        end
    endtask

    task automatic test_idle_priority();
        bit         seen;
        int         lat;
        bit         ok;
        logic [7:0] d;
        cpu_req = 1'b0;
        ld_data = 8'h3C;
        ld_strobe = 1'b1;
        tick();
        tick();
        ld_strobe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ld_busy) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL idle_pending: busy_seen=%0b mem_we=%b required 1/0", seen, mem_we);
        end
        tick();
        cpu_addr = 4'd2;
        cpu_req = 1'b1;
        #1;
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd2 || mem_wdata !== 8'h3C || cpu_gnt !== 1'b0) begin
            fails++;
            $display("FAIL idle_write: we=%b addr=%0d data=%h gnt=%b required 1/2/3c/0",
                     mem_we, mem_addr, mem_wdata, cpu_gnt);
        end
        tick();
        tests++;
        if (cpu_gnt !== 1'b1 || ld_ptr !== 4'd3) begin
            fails++;
            $display("FAIL idle_gnt_after_wr: gnt=%b ptr=%0d required 1/3", cpu_gnt, ld_ptr);
        end
        tick();
        cpu_req = 1'b0;
        ok = 1'b0;
        d = 8'h00;
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_rvalid) begin
                ok = 1'b1;
                d = cpu_rdata;
                break;
            end
        end
        tests++;
        if (!ok || d !== 8'h3C) begin
            fails++;
            $display("FAIL idle_readback: rvalid=%0b data=%h required 1/3c", ok, d);
        end
    endtask

    task automatic test_simultaneous();
        ld_mode = 1'b1;
        repeat (4) tick();
        ld_mode = 1'b0;
        repeat (4) tick();
        tests++;
        if (ld_overrun !== 1'b0 || ld_ptr !== 4'd0) begin
            fails++;
            $display("FAIL simul_mode_clear: ovr=%b ptr=%0d required 0/0", ld_overrun, ld_ptr);
        end
        cpu_req = 1'b0;
        ld_data = 8'hC1;
        ld_strobe = 1'b1;
        tick();
        ld_strobe = 1'b0;
        tick();
        ld_strobe = 1'b1;
        tick();
        ld_strobe = 1'b0;
        ld_data = 8'hC2;
        tick();
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'hC1) begin
            fails++;
            $display("FAIL simul_first_write: we=%b addr=%0d data=%h required 1/0/c1",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        tests++;
        if (ld_busy !== 1'b1 || ld_overrun !== 1'b0 || ld_ptr !== 4'd1) begin
            fails++;
            $display("FAIL simul_accept: busy=%b ovr=%b ptr=%0d required 1/0/1",
                     ld_busy, ld_overrun, ld_ptr);
        end
        tick();
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 8'hC2) begin
            fails++;
            $display("FAIL simul_second_write: we=%b addr=%0d data=%h required 1/1/c2",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        tests++;
        if (ld_busy !== 1'b0 || ld_overrun !== 1'b0 || ld_ptr !== 4'd2) begin
            fails++;
            $display("FAIL simul_end: busy=%b ovr=%b ptr=%0d required 0/0/2",
                     ld_busy, ld_overrun, ld_ptr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = 4'd0;
        ld_mode = 1'b0;
        ld_strobe = 1'b0;
        ld_data = 8'h00;
        test_reset();
        test_load_program();
        test_overrun();
        test_starvation();
        test_idle_priority();
        test_simultaneous();
        tests++;
        if (inv_n != 0) begin
            fails++;
            $display("FAIL invariants: violations=%0d required 0", inv_n);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
